// File: rtl/jtag_tap_target.sv
// Target-side IEEE 1149.1 TAP: 16-state controller, IR, bypass and test-vector
// data register. The tdo/tdoEnable outputs are launched on falling TCK.
module jtag_tap_target #(
    parameter int TEST_VECTOR_WIDTH = 32,
    parameter int INSTRUCTION_WIDTH = 5,
    parameter int VECTOR_OPCODE     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdoEnable,
    input  logic [TEST_VECTOR_WIDTH-1:0] captureVector,
    output logic [TEST_VECTOR_WIDTH-1:0] vectorOut,
    output logic                         vectorValid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [3:0]                   tapState
);

    localparam int TVW = TEST_VECTOR_WIDTH;
    localparam int IW  = INSTRUCTION_WIDTH;
    localparam logic [IW-1:0] VEC_OP     = IW'(VECTOR_OPCODE);
    localparam logic [IW-1:0] IR_CAPTURE = IW'(1);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    tap_state_e          state_q, state_d;
    logic [TVW-1:0]      vec_shift_q, vector_out_q;
    logic [IW-1:0]       ir_shift_q, instr_q;
    logic                bypass_q, vvalid_q, tdo_q, tdo_en_q;
    logic                vec_sel;

    assign vec_sel     = (instr_q == VEC_OP);
    assign tdo         = tdo_q;
    assign tdoEnable   = tdo_en_q;
    assign vectorOut   = vector_out_q;
    assign vectorValid = vvalid_q;
    assign instruction = instr_q;
    assign tapState    = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Capture/shift act on the edge leaving the state; updates act on entry,
    // so vectorValid is high for exactly the UpdateDR cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= TLR;
            vec_shift_q  <= '0;
            vector_out_q <= '0;
            ir_shift_q   <= '0;
            instr_q      <= '0;
            bypass_q     <= 1'b0;
            vvalid_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vvalid_q <= 1'b0;
            case (state_q)
                CAP_DR: begin
                    if (vec_sel) vec_shift_q <= captureVector;
                    else         bypass_q    <= 1'b0;
                end
                SH_DR: begin
                    if (vec_sel) vec_shift_q <= {tdi, vec_shift_q[TVW-1:1]};
                    else         bypass_q    <= tdi;
                end
                CAP_IR:  ir_shift_q <= IR_CAPTURE;
                SH_IR:   ir_shift_q <= {tdi, ir_shift_q[IW-1:1]};
                default: ;
            endcase
            if (state_d == TLR)    instr_q <= '0;
            if (state_d == UPD_IR) instr_q <= ir_shift_q;
            if (state_d == UPD_DR && vec_sel) begin
                vector_out_q <= vec_shift_q;
                vvalid_q     <= 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= (state_q == SH_DR) || (state_q == SH_IR);
            if (state_q == SH_DR)      tdo_q <= vec_sel ? vec_shift_q[0] : bypass_q;
            else if (state_q == SH_IR) tdo_q <= ir_shift_q[0];
            else                       tdo_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: queue-based scan-chain model checked
// every cycle, plus literal expectations for each scenario.
module tb_jtag_tap_target;

    localparam int TVW = 32;
    localparam int IW  = 5;
    localparam logic [IW-1:0] VEC_OP = 5'd1;

    logic           clk = 1'b0;
    logic           reset, tms, tdi;
    logic           tdo, tdoEnable, vectorValid;
    logic [TVW-1:0] captureVector, vectorOut;
    logic [IW-1:0]  instruction;
    logic [3:0]     tapState;

    jtag_tap_target #(
        .TEST_VECTOR_WIDTH(TVW),
        .INSTRUCTION_WIDTH(IW),
        .VECTOR_OPCODE(1)
    ) dut (
        .clk(clk), .reset(reset), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdoEnable(tdoEnable),
        .captureVector(captureVector), .vectorOut(vectorOut),
        .vectorValid(vectorValid), .instruction(instruction),
        .tapState(tapState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vv_count = 0;
    bit chk_en = 0;

    // IEEE 1149.1 graph: next state for tms=0 / tms=1
    int NXT0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int NXT1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int            m_state;
    logic [IW-1:0] m_instr;
    logic [TVW-1:0] m_vout;
    logic          m_vv;
    bit            q_dr[$];
    bit            q_ir[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_instr = '0; m_vout = '0; m_vv = 1'b0;
        q_dr.delete(); q_ir.delete();
    endtask

    // The active chain is a bit queue: the front is what tdo presents,
    // each shift pops it and appends tdi at the back.
    task automatic model_edge(input logic t, input logic d);
        int ns;
        bit sel;
        sel = (m_instr == VEC_OP);
        case (m_state)
            3: begin
                q_dr.delete();
                if (sel) for (int i = 0; i < TVW; i++) q_dr.push_back(captureVector[i]);
                else q_dr.push_back(1'b0);
            end
            4: begin void'(q_dr.pop_front()); q_dr.push_back(d); end
            10: begin
                q_ir.delete();
                for (int i = 0; i < IW; i++) q_ir.push_back(i == 0);
            end
            11: begin void'(q_ir.pop_front()); q_ir.push_back(d); end
            default: ;
        endcase
        ns = t ? NXT1[m_state] : NXT0[m_state];
        m_vv = 1'b0;
        if (ns == 0) m_instr = '0;
        if (ns == 15) for (int i = 0; i < IW; i++) m_instr[i] = q_ir[i];
        if (ns == 8 && sel) begin
            for (int i = 0; i < TVW; i++) m_vout[i] = q_dr[i];
            m_vv = 1'b1;
        end
        m_state = ns;
    endtask

    always @(negedge clk) begin
        logic etdo;
        #1;
        if (chk_en) begin
            etdo = 1'b0;
            if (m_state == 4 && q_dr.size() > 0) etdo = q_dr[0];
            if (m_state == 11 && q_ir.size() > 0) etdo = q_ir[0];
            chk("tapState", 32'(tapState), 32'(m_state));
            chk("instruction", 32'(instruction), 32'(m_instr));
            chk("tdoEnable", 32'(tdoEnable), 32'(m_state == 4 || m_state == 11));
            chk("tdo", 32'(tdo), 32'(etdo));
            chk("vectorOut", vectorOut, m_vout);
            chk("vectorValid", 32'(vectorValid), 32'(m_vv));
            if (vectorValid === 1'b1) vv_count++;
        end
    end

    task automatic tick(input logic t, input logic d);
        tms = t; tdi = d;
        @(posedge clk);
        model_edge(t, d);
        @(negedge clk);
        #2;
    endtask

    // From RTI: scan n bits of din; optional Exit1/Pause x3/Exit2 after pause_at bits.
    task automatic scan_dr(input logic [31:0] din, input int n, input int pause_at,
                           output logic [31:0] dout);
        dout = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        dout[0] = tdo;
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i == pause_at - 1), din[i]);
            if (i < n - 1 && i == pause_at - 1) begin
                tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
            end
            if (i < n - 1) dout[i + 1] = tdo;
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic scan_ir(input logic [IW-1:0] din, output logic [IW-1:0] dout);
        dout = '0;
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        dout[0] = tdo;
        for (int i = 0; i < IW; i++) begin
            tick(i == IW - 1, din[i]);
            if (i < IW - 1) dout[i + 1] = tdo;
        end
        tick(1, 0); tick(0, 0);
    endtask

    initial begin
        logic [31:0]   dout;
        logic [IW-1:0] irout;
        reset = 1'b1; tms = 1'b1; tdi = 1'b0; captureVector = '0;
        model_reset();

        #3 reset = 1'b0;
        #1;
        chk("reset_tapState", 32'(tapState), 32'd0);
        chk("reset_tdo", 32'(tdo), 32'd0);
        chk_en = 1;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0);
            chk("sync_tapState", 32'(tapState), 32'd0);
        end
        chk("sync_instruction", 32'(instruction), 32'd0);
        tick(0, 0);

        scan_dr(32'h0000_000D, 4, 0, dout);
        chk("bypass_tdo", dout[3:0], 32'hA);
        chk("bypass_no_valid", 32'(vv_count), 32'd0);

        scan_ir(5'b00001, irout);
        chk("ir_capture_tdo", 32'(irout), 32'h01);
        chk("ir_update", 32'(instruction), 32'd1);

        captureVector = 32'hA5A5_0F0F;
        scan_dr(32'h1234_5678, 32, 0, dout);
        chk("vec_tdo", dout, 32'hA5A5_0F0F);
        chk("vec_out", vectorOut, 32'h1234_5678);
        chk("vec_pulses", 32'(vv_count), 32'd1);

        captureVector = 32'h0F0F_A5A5;
        scan_dr(32'h1234_5678, 32, 10, dout);
        chk("pause_tdo", dout, 32'h0F0F_A5A5);
        chk("pause_out", vectorOut, 32'h1234_5678);
        chk("pause_pulses", 32'(vv_count), 32'd2);

        scan_ir(5'b11111, irout);
        chk("ones_instruction", 32'(instruction), 32'h1F);
        scan_dr(32'h0000_0003, 4, 0, dout);
        chk("ones_bypass_tdo", dout[3:0], 32'h6);
        chk("ones_no_valid", 32'(vv_count), 32'd2);

        scan_ir(5'b00001, irout);
        captureVector = 32'hA5A5_0F0F;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1'(i % 3 == 0));
        reset = 1'b0;
        #1;
        chk("midrst_tapState", 32'(tapState), 32'd0);
        chk("midrst_instruction", 32'(instruction), 32'd0);
        chk("midrst_vectorOut", vectorOut, 32'd0);
        chk("midrst_tdoEnable", 32'(tdoEnable), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        tick(1, 0);
        chk("midrst_no_valid", 32'(vv_count), 32'd2);

        tick(0, 0);
        scan_ir(5'b00001, irout);
        tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        chk("tlr_from_pause", 32'(tapState), 32'd0);
        chk("tlr_instruction", 32'(instruction), 32'd0);
        chk("tlr_path_pulses", 32'(vv_count), 32'd3);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
